fwft_prefetch_ctrl: RTL and testbench

Parametrised first-word-fall-through (FWFT) prefetch controller that sits between a standard-read sync FIFO core and a consumer. The core has a fixed RAM read latency.
- Replaces the one-hot prefetch scheme with a ring buffer plus explicit in-flight accounting.
- Adds a programmable prefetch cap, discard of stale returns after clear, an error sideband carried with the data, and an exact data_count.
- Single clock domain. Instantiated once per FIFO on the read side.

---
 rtl/fwft_prefetch_ctrl_if.sv | 36 +++
 rtl/fwft_prefetch_ctrl.sv | 129 ++++++++++++
 tb/tb_fwft_prefetch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwft_prefetch_ctrl_if.sv
// Read-side bundle of the FWFT prefetch controller: the standard-read core port on one
// side and the first-word-fall-through consumer port on the other.
interface fwft_prefetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 102,
  parameter int unsigned SB_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH  = 5
) ();

  // Core FIFO read port
  logic                  core_empty;
  logic                  core_rd_en;
  logic [DATA_WIDTH-1:0] core_rd_data;
  logic [SB_WIDTH-1:0]   core_rd_sb;
  logic                  core_rd_data_val;
  logic [CNT_WIDTH-1:0]  core_data_count;

  // Consumer FWFT port
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [SB_WIDTH-1:0]   rd_sb;
  logic                  rd_data_val;
  logic                  empty;

  // Controller view
  modport master (
    input  core_empty, core_rd_data, core_rd_sb, core_rd_data_val, core_data_count, rd_en,
    output core_rd_en, rd_data, rd_sb, rd_data_val, empty
  );

  // Environment view (core model and consumer)
  modport slave (
    output core_empty, core_rd_data, core_rd_sb, core_rd_data_val, core_data_count, rd_en,
    input  core_rd_en, rd_data, rd_sb, rd_data_val, empty
  );

endinterface

// File: rtl/fwft_prefetch_ctrl.sv
// FWFT prefetch controller: issues reads to a fixed-latency core FIFO, lands the returns in a
// small ring buffer and presents the head word registered to the consumer. In-flight reads are
// counted explicitly so a clear can discard the stale returns that are still in the RAM pipe.
module fwft_prefetch_ctrl #(
  parameter int unsigned DATA_WIDTH     = 102,
  parameter int unsigned SB_WIDTH       = 2,
  parameter int unsigned RAM_PIPE_STAGE = 2,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic [$clog2(RAM_PIPE_STAGE+3)-1:0]  pref_limit,
  fwft_prefetch_ctrl_if.master                 bus,
  output logic [CNT_WIDTH:0]                   data_count,
  output logic                                 udf_int,
  output logic                                 proto_err
);

  localparam int unsigned PRE_REG_NUM = RAM_PIPE_STAGE + 2;
  localparam int unsigned LW          = $clog2(PRE_REG_NUM + 1);
  localparam int unsigned PW          = $clog2(PRE_REG_NUM);
  localparam int unsigned WW          = DATA_WIDTH + SB_WIDTH;

  localparam logic [LW-1:0] LimMax  = LW'(PRE_REG_NUM);
  localparam logic [PW-1:0] PtrLast = PW'(PRE_REG_NUM - 1);

  logic [WW-1:0] mem_q [PRE_REG_NUM];
  logic [WW-1:0] head;

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] occ_q, occ_d, infl_q, infl_d, drop_q, drop_d;
  logic          udf_q, udf_d, proto_q, proto_d;

  logic [LW-1:0] eff_lim;
  logic [LW:0]   level;
  logic [LW:0]   pend;
  logic          issue, push, pop, stray, head_val;

  // Issue, return and pop qualifiers
  always_comb begin
    eff_lim  = (pref_limit == '0 || pref_limit > LimMax) ? LimMax : pref_limit;
    level    = {1'b0, occ_q} + {1'b0, infl_q};
    head_val = (occ_q != '0);
    // No credit is taken for a same-cycle pop, so issue never depends on rd_en.
    issue    = ~bus.core_empty & ~clear & (drop_q == '0) & (level < {1'b0, eff_lim});
    push     = bus.core_rd_data_val & (drop_q == '0) & (infl_q != '0) & ~clear;
    stray    = bus.core_rd_data_val & (drop_q == '0) & (infl_q == '0);
    pop      = bus.rd_en & head_val;
    // Outstanding returns to throw away; only one of drop/infl can be non-zero here.
    pend     = {1'b0, drop_q} + {1'b0, infl_q};
  end

  // Next-state for pointers, counters and flags
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    occ_d   = occ_q;
    infl_d  = infl_q;
    drop_d  = drop_q;
    udf_d   = udf_q;
    proto_d = proto_q;
    if (clear) begin
      wp_d    = '0;
      rp_d    = '0;
      occ_d   = '0;
      infl_d  = '0;
      drop_d  = (pend != '0) ? LW'(pend - (LW+1)'(bus.core_rd_data_val)) : '0;
      udf_d   = 1'b0;
      proto_d = 1'b0;
    end else begin
      if (push) begin
        wp_d = (wp_q == PtrLast) ? '0 : wp_q + PW'(1);
      end
      if (pop) begin
        rp_d = (rp_q == PtrLast) ? '0 : rp_q + PW'(1);
      end
      occ_d  = occ_q + LW'(push) - LW'(pop);
      infl_d = infl_q + LW'(issue) - LW'(push);
      if (drop_q != '0 && bus.core_rd_data_val) begin
        drop_d = drop_q - LW'(1);
      end
      udf_d   = bus.rd_en & ~head_val;
      proto_d = proto_q | stray;
    end
  end

  // State registers and ring buffer, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
      udf_q   <= 1'b0;
      proto_q <= 1'b0;
      for (int unsigned i = 0; i < PRE_REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
      udf_q   <= udf_d;
      proto_q <= proto_d;
      if (push) begin
        mem_q[wp_q] <= {bus.core_rd_sb, bus.core_rd_data};
      end
    end
  end

  // Outputs: head word straight from the buffer registers, counts combinational
  always_comb begin
    head            = mem_q[rp_q];
    bus.rd_data     = head[DATA_WIDTH-1:0];
    bus.rd_sb       = head[WW-1:DATA_WIDTH];
    bus.rd_data_val = head_val;
    bus.empty       = ~head_val;
    bus.core_rd_en  = issue;
    data_count      = (CNT_WIDTH+1)'(bus.core_data_count) + (CNT_WIDTH+1)'(occ_q)
                    + (CNT_WIDTH+1)'(infl_q);
    udf_int         = udf_q;
    proto_err       = proto_q;
  end

endmodule

// File: tb/tb_fwft_prefetch_ctrl.sv
// Bench for fwft_prefetch_ctrl: a fixed-latency core FIFO model feeds the DUT, and a queue-based
// reference (words in core, words in flight, words buffered, ghosts to discard) predicts every
// output each cycle. Directed scenarios pin the reference with literal values, then random
// traffic with clears and cap changes runs against it.
module tb_fwft_prefetch_ctrl;

  localparam int DW  = 102;
  localparam int SBW = 2;
  localparam int RPS = 2;
  localparam int CW  = 5;
  localparam int PRE = RPS + 2;
  localparam int LW  = $clog2(PRE + 1);
  localparam int WW  = DW + SBW;

  typedef logic [WW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] pref_limit = '0;
  logic [CW:0]   data_count;
  logic          udf_int, proto_err;

  fwft_prefetch_ctrl_if #(.DATA_WIDTH(DW), .SB_WIDTH(SBW), .CNT_WIDTH(CW)) bus ();

  fwft_prefetch_ctrl #(
    .DATA_WIDTH(DW), .SB_WIDTH(SBW), .RAM_PIPE_STAGE(RPS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .pref_limit(pref_limit), .bus(bus),
    .data_count(data_count), .udf_int(udf_int), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Core FIFO model with RPS-cycle read latency
  word_t core_q[$];
  word_t pipe_w [RPS];
  logic  pipe_v [RPS];
  logic  inject = 1'b0;

  // Reference model
  word_t buf_q[$];
  int    fly = 0;
  int    ghosts = 0;
  logic  udf_m = 1'b0;
  logic  proto_m = 1'b0;
  logic  en_m;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[WW-1:0];
  endfunction

  function automatic int eff_lim();
    return (pref_limit == '0 || int'(pref_limit) > PRE) ? PRE : int'(pref_limit);
  endfunction

  function automatic bit pipe_any();
    bit a = 0;
    for (int k = 0; k < RPS; k++) a |= pipe_v[k];
    return a;
  endfunction

  // Drive the core side, let the DUT settle, compare every output with the reference
  task automatic settle();
    word_t w;
    w = pipe_w[RPS-1];
    bus.core_empty       = (core_q.size() == 0);
    bus.core_data_count  = CW'(core_q.size());
    bus.core_rd_data_val = pipe_v[RPS-1] | inject;
    bus.core_rd_data     = w[DW-1:0];
    bus.core_rd_sb       = w[WW-1:DW];
    en_m = rst_n && core_q.size() > 0 && !clear && ghosts == 0
           && (buf_q.size() + fly < eff_lim());
    #1;
    if (rst_n) begin
      chk("rd_data_val", bus.rd_data_val, buf_q.size() != 0);
      chk("empty", bus.empty, buf_q.size() == 0);
      if (buf_q.size() != 0) chk("rd_word", {bus.rd_sb, bus.rd_data}, buf_q[0]);
      chk("core_rd_en", bus.core_rd_en, en_m);
      chk("data_count", data_count, core_q.size() + buf_q.size() + fly);
      chk("udf_int", udf_int, udf_m);
      chk("proto_err", proto_err, proto_m);
    end
  endtask

  // Clock edge: advance core model and reference from the inputs of the cycle just ended
  task automatic advance();
    word_t ret;
    logic  val;
    val = bus.core_rd_data_val;
    ret = pipe_w[RPS-1];
    @(posedge clk);
    for (int k = RPS - 1; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_w[k] = pipe_w[k-1];
    end
    pipe_v[0] = en_m;
    if (en_m) pipe_w[0] = core_q.pop_front();
    if (!rst_n) begin
      buf_q.delete();
      fly = 0; ghosts = 0; udf_m = 0; proto_m = 0;
    end else if (clear) begin
      buf_q.delete();
      ghosts = ghosts + fly - int'(val);
      if (ghosts < 0) ghosts = 0;
      fly = 0; udf_m = 0; proto_m = 0;
    end else begin
      udf_m = bus.rd_en && buf_q.size() == 0;
      if (bus.rd_en && buf_q.size() != 0) void'(buf_q.pop_front());
      if (val) begin
        if (ghosts > 0) ghosts--;
        else if (fly > 0) begin
          fly--;
          buf_q.push_back(ret);
        end else proto_m = 1;
      end
      if (en_m) fly++;
    end
    @(negedge clk);
  endtask

  // Pop everything out, then leave one idle cycle so udf_int is known to be low
  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (buf_q.size() == 0 && fly == 0 && ghosts == 0 && core_q.size() == 0 && !pipe_any())
        break;
      bus.rd_en = (buf_q.size() != 0);
      settle();
      advance();
    end
    bus.rd_en = 1'b0;
    settle();
    chk("drain_idle", bus.rd_data_val, 1'b0);
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t a, b, c;
    int    pc[$];
    int    npop, first, last;
    bit    started;

    for (int k = 0; k < RPS; k++) begin
      pipe_v[k] = 1'b0;
      pipe_w[k] = '0;
    end
    bus.rd_en = 1'b0;
    @(negedge clk);

    // Reset state
    rst_n = 1'b0;
    repeat (2) begin settle(); advance(); end
    rst_n = 1'b1;
    settle();
    chk("rst_val", bus.rd_data_val, 1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_rd_sb", bus.rd_sb, '0);
    chk("rst_core_rd_en", bus.core_rd_en, 1'b0);
    chk("rst_count", data_count, 0);
    advance();

    // Basic FWFT: three words, no consumer
    a = rand_word(); b = rand_word(); c = rand_word();
    core_q.push_back(a); core_q.push_back(b); core_q.push_back(c);
    for (int cy = 0; cy < 6; cy++) begin
      settle();
      chk("t1_en", bus.core_rd_en, cy < 3);
      chk("t1_val", bus.rd_data_val, cy >= 3);
      chk("t1_cnt", data_count, 3);
      if (cy == 3) chk("t1_head", {bus.rd_sb, bus.rd_data}, a);
      advance();
    end
    drain();

    // Streaming: 20 words back to back
    for (int i = 0; i < 20; i++) core_q.push_back(rand_word());
    started = 0; npop = 0; first = -1; last = -1;
    for (int cy = 0; cy < 60; cy++) begin
      if (!started && buf_q.size() != 0) started = 1;
      bus.rd_en = started && npop < 20;
      settle();
      chk("t2_udf", udf_int, 1'b0);
      if (bus.rd_en && bus.rd_data_val) begin
        npop++;
        if (first < 0) first = cy;
        last = cy;
      end
      advance();
    end
    bus.rd_en = 1'b0;
    settle();
    chk("t2_npop", npop, 20);
    chk("t2_span", last - first + 1, 20);
    chk("t2_empty", bus.empty, 1'b1);
    chk("t2_count", data_count, 0);
    advance();

    // Prefetch cap of one: a pop every 4th cycle
    pref_limit = LW'(1);
    for (int i = 0; i < 4; i++) core_q.push_back(rand_word());
    bus.rd_en = 1'b1;
    pc.delete();
    for (int cy = 0; cy < 18; cy++) begin
      settle();
      if (bus.rd_en && bus.rd_data_val) pc.push_back(cy);
      advance();
    end
    chk("t3_npop", pc.size(), 4);
    for (int i = 0; i < pc.size(); i++) chk("t3_pop_cyc", pc[i], 3 + 4 * i);
    // Cap removed: back-to-back again
    pref_limit = '0;
    for (int i = 0; i < 4; i++) core_q.push_back(rand_word());
    pc.delete();
    for (int cy = 0; cy < 10; cy++) begin
      settle();
      if (bus.rd_en && bus.rd_data_val) pc.push_back(cy);
      advance();
    end
    chk("t3b_npop", pc.size(), 4);
    for (int i = 0; i < pc.size(); i++) chk("t3b_pop_cyc", pc[i], 3 + i);
    bus.rd_en = 1'b0;
    drain();

    // Clear with two reads in flight
    for (int i = 0; i < 5; i++) core_q.push_back(rand_word());
    settle(); advance();
    settle(); advance();
    clear = 1'b1;
    settle();
    chk("t4_en_clr", bus.core_rd_en, 1'b0);
    advance();
    clear = 1'b0;
    settle();
    chk("t4_en_drop", bus.core_rd_en, 1'b0);
    chk("t4_val", bus.rd_data_val, 1'b0);
    chk("t4_cnt", data_count, 3);
    advance();
    settle();
    chk("t4_en_resume", bus.core_rd_en, 1'b1);
    chk("t4_val2", bus.rd_data_val, 1'b0);
    chk("t4_proto", proto_err, 1'b0);
    advance();
    drain();

    // Underflow: two cycles of rd_en while empty
    for (int cy = 0; cy < 4; cy++) begin
      bus.rd_en = (cy < 2);
      settle();
      chk("t5_udf", udf_int, cy == 1 || cy == 2);
      advance();
    end
    // Protocol error: return with nothing in flight
    inject = 1'b1;
    settle();
    chk("t5_proto_pre", proto_err, 1'b0);
    advance();
    inject = 1'b0;
    for (int cy = 0; cy < 3; cy++) begin
      settle();
      chk("t5_proto_sticky", proto_err, 1'b1);
      advance();
    end
    clear = 1'b1;
    settle(); advance();
    clear = 1'b0;
    settle();
    chk("t5_proto_clr", proto_err, 1'b0);
    advance();

    // Reset with occ=3, infl=1
    for (int i = 0; i < 3; i++) core_q.push_back(rand_word());
    for (int cy = 0; cy < 5; cy++) begin settle(); advance(); end
    core_q.push_back(rand_word());
    settle(); advance();
    settle();
    chk("t6_pre_cnt", data_count, 4);
    rst_n = 1'b0;
    settle(); advance();
    rst_n = 1'b1;
    settle();
    chk("t6_val", bus.rd_data_val, 1'b0);
    chk("t6_cnt", data_count, 0);
    chk("t6_rd_data", bus.rd_data, '0);
    chk("t6_rd_sb", bus.rd_sb, '0);
    advance();
    settle();
    chk("t6_proto", proto_err, 1'b1);
    advance();
    clear = 1'b1;
    settle(); advance();
    clear = 1'b0;
    drain();

    // Random traffic with clears and cap changes
    for (int cy = 0; cy < 4000; cy++) begin
      if ($urandom_range(0, 99) < 40 && core_q.size() < 26) core_q.push_back(rand_word());
      bus.rd_en = ($urandom_range(0, 99) < 60);
      clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 49) == 0) pref_limit = LW'($urandom_range(0, 7));
      settle();
      advance();
    end
    clear = 1'b0;
    pref_limit = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
